mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 161 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add / restoring divide,
// fixed 33-cycle latency from the accepted start to the registered done pulse.
module mul_div_unit (
    input  logic        m_clock,
    input  logic        p_reset,
    input  logic        start,
    input  logic        kill,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic        rd,
    output logic [4:0]  rd_n,
    output logic [31:0] wd
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q;
    logic [2:0]  op_q;
    logic        neg_q;
    logic [4:0]  dest_q;
    logic [31:0] hi_q, lo_q, b_q;
    logic        done_q, rd_q;
    logic [4:0]  rd_n_q;
    logic [31:0] wd_q;

    logic        accept, last;
    logic        a_signed, b_signed, a_neg, b_neg, res_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum, div_shift;
    logic [33:0] div_diff;
    logic [31:0] hi_step, lo_step;
    logic [63:0] prod, prod_fix;
    logic [31:0] div_sel, div_fix, result;

    assign accept = (state_q == StIdle) && start && !kill;
    assign last   = (state_q == StCalc) && (cnt_q == 6'd31);
    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign rd     = rd_q;
    assign rd_n   = rd_n_q;
    assign wd     = wd_q;

    // Operand sign handling: magnitudes go into the datapath, sign fixed up at the end.
    always_comb begin
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg    = a_signed && op_a[31];
        b_neg    = b_signed && op_b[31];
        a_mag    = a_neg ? (~op_a + 32'd1) : op_a;
        b_mag    = b_neg ? (~op_b + 32'd1) : op_b;
        if (funct3[2] && funct3[1]) begin
            res_neg = a_neg;
        end else if (funct3[2]) begin
            // Divide by zero must yield all ones regardless of the dividend sign.
            res_neg = (a_neg ^ b_neg) && (op_b != 32'd0);
        end else begin
            res_neg = a_neg ^ b_neg;
        end
    end

    // One iteration: lo holds multiplier / dividend, hi holds partial product / remainder.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
        div_shift = {hi_q, lo_q[31]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_q};
        if (op_q[2]) begin
            hi_step = div_diff[33] ? div_shift[31:0] : div_diff[31:0];
            lo_step = {lo_q[30:0], ~div_diff[33]};
        end else begin
            hi_step = mul_sum[32:1];
            lo_step = {mul_sum[0], lo_q[31:1]};
        end
    end

    always_comb begin
        prod     = {hi_step, lo_step};
        prod_fix = neg_q ? (~prod + 64'd1) : prod;
        div_sel  = op_q[1] ? hi_step : lo_step;
        div_fix  = neg_q ? (~div_sel + 32'd1) : div_sel;
        if (op_q[2]) begin
            result = div_fix;
        end else if (op_q[1:0] == 2'b00) begin
            result = prod_fix[31:0];
        end else begin
            result = prod_fix[63:32];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StCalc;
            StCalc:  if (cnt_q == 6'd31) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (kill) state_d = StIdle;
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge m_clock) begin
        if (p_reset || state_q != StCalc) begin
            cnt_q <= 6'd0;
        end else begin
            cnt_q <= cnt_q + 6'd1;
        end
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            op_q   <= 3'd0;
            neg_q  <= 1'b0;
            dest_q <= 5'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            b_q    <= 32'd0;
        end else if (accept) begin
            op_q   <= funct3;
            neg_q  <= res_neg;
            dest_q <= rd_in;
            hi_q   <= 32'd0;
            lo_q   <= a_mag;
            b_q    <= b_mag;
        end else if (state_q == StCalc) begin
            hi_q <= hi_step;
            lo_q <= lo_step;
        end
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            done_q <= 1'b0;
            rd_q   <= 1'b0;
            rd_n_q <= 5'd0;
            wd_q   <= 32'd0;
        end else begin
            done_q <= 1'b0;
            rd_q   <= 1'b0;
            if (last && !kill) begin
                done_q <= 1'b1;
                rd_q   <= (dest_q != 5'd0);
                rd_n_q <= dest_q;
                wd_q   <= result;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, control corner
// sequences and randomized operations checked against an arithmetic model.
module tb_mul_div_unit;

    logic        m_clock, p_reset, start, kill;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        busy, done, rd;
    logic [4:0]  rd_n;
    logic [31:0] wd;

    int errors = 0;
    int checks = 0;

    mul_div_unit dut (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .start   (start),
        .kill    (kill),
        .funct3  (funct3),
        .op_a    (op_a),
        .op_b    (op_b),
        .rd_in   (rd_in),
        .busy    (busy),
        .done    (done),
        .rd      (rd),
        .rd_n    (rd_n),
        .wd      (wd)
    );

    initial m_clock = 1'b0;
    always #5 m_clock = ~m_clock;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rdi;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        int ia, ib;
        logic ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ub  = {32'd0, b};
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        model = 32'd0;
        case (f)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; model = p[31:0]; end
            3'd1: begin p = sa * sb; model = p[63:32]; end
            3'd2: begin p = sa * ub; model = p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; model = p[63:32]; end
            3'd4: model = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: model = (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: model = (b == 0) ? a : a % b;
        endcase
    endfunction

    // Called at a falling edge (cycle T); returns at the falling edge of T+1.
    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rdi);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        rd_in  = rdi;
        start  = 1'b1;
        @(negedge m_clock);
        start  = 1'b0;
        op_a   = $urandom;
        op_b   = $urandom;
        funct3 = 3'($urandom);
        rd_in  = 5'($urandom);
    endtask

    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rdi, input logic [31:0] exp,
                         input bit extra);
        int n;
        bit busy_ok;
        busy_ok = 1'b1;
        launch(f, a, b, rdi);
        for (n = 1; n <= 40; n++) begin
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            start = extra && (n == 5);
            @(negedge m_clock);
        end
        start = 1'b0;
        chk({tag, ".latency"}, 32'(n), 32'd33);
        chk({tag, ".busy_calc"}, 32'(busy_ok), 32'd1);
        chk({tag, ".busy_done"}, 32'(busy), 32'd1);
        chk({tag, ".wd"}, wd, exp);
        chk({tag, ".rd"}, 32'(rd), 32'(rdi != 5'd0));
        chk({tag, ".rd_n"}, 32'(rd_n), 32'(rdi));
        @(negedge m_clock);
        chk({tag, ".idle_after"}, {29'd0, busy, done, rd}, 32'd0);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE};
        vecs[2]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3,  32'hFFFF_FFFF};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4,  32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF};
        vecs[6]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  32'h8000_0000};
        vecs[7]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h0000_0000};
        vecs[8]  = '{3'd5, 32'h0000_0005, 32'h0000_0000, 5'd9,  32'hFFFF_FFFF};
        vecs[9]  = '{3'd7, 32'h0000_0005, 32'h0000_0000, 5'd10, 32'h0000_0005};
        vecs[10] = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0000, 5'd0,  32'hFFFF_FFFF};
        vecs[11] = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 5'd31, 32'hFFFF_FFF9};

        p_reset = 1'b1;
        start   = 1'b0;
        kill    = 1'b0;
        funct3  = 3'd0;
        op_a    = 32'd0;
        op_b    = 32'd0;
        rd_in   = 5'd0;
        repeat (3) @(negedge m_clock);
        chk("reset.ctrl", {29'd0, busy, done, rd}, 32'd0);
        chk("reset.rd_n", 32'(rd_n), 32'd0);
        chk("reset.wd", wd, 32'd0);
        p_reset = 1'b0;
        @(negedge m_clock);

        for (int i = 0; i < 12; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rdi,
                  vecs[i].exp, 1'b0);
        end

        // Second start at T+5 ignored; the first result comes back alone at T+33.
        do_op("restart", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b1);

        // Kill beats start in IDLE.
        start = 1'b1;
        kill  = 1'b1;
        @(negedge m_clock);
        start = 1'b0;
        kill  = 1'b0;
        chk("kill_vs_start.busy", 32'(busy), 32'd0);
        @(negedge m_clock);

        // Kill at T+10, new start at T+11 accepted with a clean 33-cycle latency.
        launch(3'd5, 32'd100, 32'd7, 5'd12);
        repeat (9) @(negedge m_clock);
        kill = 1'b1;
        @(negedge m_clock);
        kill = 1'b0;
        chk("kill.busy", 32'(busy), 32'd0);
        chk("kill.pulse", {30'd0, done, rd}, 32'd0);
        do_op("after_kill", 3'd7, 32'd100, 32'd7, 5'd13, 32'd2, 1'b0);

        // Reset at T+20 clears every output at T+21 and nothing follows.
        launch(3'd0, 32'd3, 32'd4, 5'd14);
        repeat (19) @(negedge m_clock);
        p_reset = 1'b1;
        @(negedge m_clock);
        chk("midreset.ctrl", {29'd0, busy, done, rd}, 32'd0);
        chk("midreset.rd_n", 32'(rd_n), 32'd0);
        chk("midreset.wd", wd, 32'd0);
        p_reset = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (40) begin
                @(negedge m_clock);
                if (done || rd || busy) seen++;
            end
            chk("midreset.quiet", 32'(seen), 32'd0);
        end

        for (int i = 0; i < 150; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            logic [4:0]  r;
            f = 3'($urandom);
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = -32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            r = 5'($urandom);
            do_op($sformatf("rand%0d", i), f, a, b, r, model(f, a, b), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
